// File: rtl/overcurrent_guard.sv
// Overcurrent guard: block-average and instantaneous-peak trip detection with
// timed motor hold-off after each trip and a latched lockout once the trip
// budget is spent. All outputs come straight from flops.
module overcurrent_guard #(
    parameter logic [15:0] AVG_THRESH     = 16'd1000,
    parameter logic [15:0] PEAK_THRESH    = 16'd2000,
    parameter int unsigned AVG_LOG2       = 3,
    parameter int unsigned HOLDOFF_CYCLES = 100_000_000,
    parameter int unsigned MAX_TRIPS      = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] current_value,
    input  logic        sample_valid,
    input  logic        clear,
    output logic        motor_enable,
    output logic        motor_reset,
    output logic [15:0] avg_value,
    output logic [1:0]  trip_count,
    output logic        fault_latched
);

    // Accumulator holds up to 2^AVG_LOG2 full-scale samples without overflow.
    localparam int unsigned       ACC_W     = 16 + AVG_LOG2;
    localparam int unsigned       HOLD_W    = $clog2(HOLDOFF_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 32'd1);
    localparam logic [AVG_LOG2-1:0] CNT_LAST = {AVG_LOG2{1'b1}};
    localparam logic [1:0]        MAX_T     = 2'(MAX_TRIPS);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [AVG_LOG2-1:0] cnt_q, cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [15:0]         avg_q, avg_d;
    logic                avg_chk_q, avg_chk_d;
    logic [1:0]          trip_cnt_q, trip_cnt_d;
    logic                motor_en_q, motor_en_d;
    logic                motor_rst_q, motor_rst_d;
    logic                fault_q, fault_d;

    logic [ACC_W-1:0]    sum_s;
    logic                peak_s;
    logic                avg_trip_s;
    logic                trip_s;

    // Next-state logic: window accumulation, trip detection, hold-off timing, lockout.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        avg_d      = avg_q;
        avg_chk_d  = 1'b0;
        // Clear is applied before any trip on the same edge.
        trip_cnt_d = clear ? 2'd0 : trip_cnt_q;

        sum_s      = acc_q + {{AVG_LOG2{1'b0}}, current_value};
        peak_s     = sample_valid && (current_value >= PEAK_THRESH);
        // Average comparison happens one edge after the average is loaded.
        avg_trip_s = avg_chk_q && (avg_q > AVG_THRESH);
        trip_s     = peak_s || avg_trip_s;

        case (state_q)
            ST_RUN: begin
                if (trip_s) begin
                    if (trip_cnt_d != MAX_T) begin
                        trip_cnt_d = trip_cnt_d + 2'd1;
                    end else begin
                        trip_cnt_d = MAX_T;
                    end
                    acc_d  = {ACC_W{1'b0}};
                    cnt_d  = {AVG_LOG2{1'b0}};
                    hold_d = {HOLD_W{1'b0}};
                    if (trip_cnt_d == MAX_T) begin
                        state_d = ST_LOCKOUT;
                    end else begin
                        state_d = ST_HOLDOFF;
                    end
                end else if (sample_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        avg_d     = sum_s[ACC_W-1:AVG_LOG2];
                        acc_d     = {ACC_W{1'b0}};
                        cnt_d     = {AVG_LOG2{1'b0}};
                        avg_chk_d = 1'b1;
                    end else begin
                        acc_d = sum_s;
                        cnt_d = cnt_q + AVG_LOG2'(1'b1);
                    end
                end else begin
                    acc_d = acc_q;
                end
            end
            ST_HOLDOFF: begin
                // The entry edge counts as the first hold-off edge.
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    hold_d  = {HOLD_W{1'b0}};
                end else begin
                    hold_d = hold_q + HOLD_W'(1'b1);
                end
            end
            ST_LOCKOUT: begin
                if (clear) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_LOCKOUT;
                end
            end
            default: begin
                state_d = ST_RUN;
                acc_d   = {ACC_W{1'b0}};
                cnt_d   = {AVG_LOG2{1'b0}};
                hold_d  = {HOLD_W{1'b0}};
            end
        endcase

        motor_en_d  = (state_d == ST_RUN);
        motor_rst_d = (state_d != ST_RUN);
        fault_d     = (state_d == ST_LOCKOUT);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {AVG_LOG2{1'b0}};
            hold_q      <= {HOLD_W{1'b0}};
            avg_q       <= 16'd0;
            avg_chk_q   <= 1'b0;
            trip_cnt_q  <= 2'd0;
            motor_en_q  <= 1'b1;
            motor_rst_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            avg_q       <= avg_d;
            avg_chk_q   <= avg_chk_d;
            trip_cnt_q  <= trip_cnt_d;
            motor_en_q  <= motor_en_d;
            motor_rst_q <= motor_rst_d;
            fault_q     <= fault_d;
        end
    end

    assign motor_enable  = motor_en_q;
    assign motor_reset   = motor_rst_q;
    assign avg_value     = avg_q;
    assign trip_count    = trip_cnt_q;
    assign fault_latched = fault_q;

endmodule

// File: tb/tb_overcurrent_guard.sv
// Scoreboard bench for overcurrent_guard (HOLDOFF_CYCLES shortened to 100).
module tb_overcurrent_guard;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] current_value = 16'd0;
    logic        sample_valid = 1'b0;
    logic        clear = 1'b0;
    logic        motor_enable;
    logic        motor_reset;
    logic [15:0] avg_value;
    logic [1:0]  trip_count;
    logic        fault_latched;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic        me;
        logic [15:0] avg;
        logic [1:0]  tc;
        logic        fl;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    overcurrent_guard #(
        .AVG_THRESH    (16'd1000),
        .PEAK_THRESH   (16'd2000),
        .AVG_LOG2      (3),
        .HOLDOFF_CYCLES(100),
        .MAX_TRIPS     (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .current_value(current_value),
        .sample_valid (sample_valid),
        .clear        (clear),
        .motor_enable (motor_enable),
        .motor_reset  (motor_reset),
        .avg_value    (avg_value),
        .trip_count   (trip_count),
        .fault_latched(fault_latched)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: compare every expectation due after the most recent rising edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (motor_enable !== mon_e.me) begin
                failures++;
                $display("FAIL %s.motor_enable cyc=%0d got=%0b exp=%0b", mon_e.tag, cyc, motor_enable, mon_e.me);
            end
            checks++;
            if (motor_reset !== ~mon_e.me) begin
                failures++;
                $display("FAIL %s.motor_reset cyc=%0d got=%0b exp=%0b", mon_e.tag, cyc, motor_reset, ~mon_e.me);
            end
            checks++;
            if (avg_value !== mon_e.avg) begin
                failures++;
                $display("FAIL %s.avg_value cyc=%0d got=%0d exp=%0d", mon_e.tag, cyc, avg_value, mon_e.avg);
            end
            checks++;
            if (trip_count !== mon_e.tc) begin
                failures++;
                $display("FAIL %s.trip_count cyc=%0d got=%0d exp=%0d", mon_e.tag, cyc, trip_count, mon_e.tc);
            end
            checks++;
            if (fault_latched !== mon_e.fl) begin
                failures++;
                $display("FAIL %s.fault_latched cyc=%0d got=%0b exp=%0b", mon_e.tag, cyc, fault_latched, mon_e.fl);
            end
        end
    end

    // Drive one edge of stimulus and queue the outputs expected after that edge.
    task automatic step(input logic v, input logic [15:0] val, input logic clr,
                        input logic e_me, input logic [15:0] e_avg, input logic [1:0] e_tc,
                        input logic e_fl, input string tag);
        exp_t e;
        @(negedge clk);
        sample_valid  = v;
        current_value = val;
        clear         = clr;
        e.due = cyc + 1;
        e.me  = e_me;
        e.avg = e_avg;
        e.tc  = e_tc;
        e.fl  = e_fl;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Let the scoreboard consume the last queued expectation and idle the inputs.
    task automatic drain();
        @(negedge clk);
        sample_valid  = 1'b0;
        current_value = 16'd0;
        clear         = 1'b0;
        #1;
    endtask

    // 99 edges held off (samples offered and ignored), then motor returns on edge 100.
    task automatic holdoff(input logic [15:0] avg, input logic [1:0] tc);
        for (int i = 0; i < 99; i++) step(1'b1, 16'd3000, 1'b0, 1'b0, avg, tc, 1'b0, "holdoff_off");
        step(1'b0, 16'd0, 1'b0, 1'b1, avg, tc, 1'b0, "holdoff_release");
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        checks++; if (motor_enable !== 1'b1) begin failures++; $display("FAIL reset.motor_enable got=%0b exp=1", motor_enable); end
        checks++; if (motor_reset !== 1'b0) begin failures++; $display("FAIL reset.motor_reset got=%0b exp=0", motor_reset); end
        checks++; if (avg_value !== 16'd0) begin failures++; $display("FAIL reset.avg_value got=%0d exp=0", avg_value); end
        checks++; if (trip_count !== 2'd0) begin failures++; $display("FAIL reset.trip_count got=%0d exp=0", trip_count); end
        checks++; if (fault_latched !== 1'b0) begin failures++; $display("FAIL reset.fault_latched got=%0b exp=0", fault_latched); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_avg_equal();
        for (int i = 0; i < 7; i++) step(1'b1, 16'd1000, 1'b0, 1'b1, 16'd0, 2'd0, 1'b0, "avg_eq_fill");
        step(1'b1, 16'd1000, 1'b0, 1'b1, 16'd1000, 2'd0, 1'b0, "avg_eq_load");
        step(1'b0, 16'd0, 1'b0, 1'b1, 16'd1000, 2'd0, 1'b0, "avg_eq_notrip");
        step(1'b0, 16'd0, 1'b0, 1'b1, 16'd1000, 2'd0, 1'b0, "avg_eq_notrip2");
    endtask

    task automatic test_avg_trip();
        for (int i = 0; i < 7; i++) step(1'b1, 16'd1001, 1'b0, 1'b1, 16'd1000, 2'd0, 1'b0, "avg_gt_fill");
        step(1'b1, 16'd1001, 1'b0, 1'b1, 16'd1001, 2'd0, 1'b0, "avg_gt_load");
        step(1'b0, 16'd0, 1'b0, 1'b0, 16'd1001, 2'd1, 1'b0, "avg_gt_trip");
        holdoff(16'd1001, 2'd1);
    endtask

    task automatic test_peak_mid();
        for (int i = 0; i < 3; i++) step(1'b1, 16'd500, 1'b0, 1'b1, 16'd1001, 2'd1, 1'b0, "peak_prefill");
        step(1'b1, 16'd2000, 1'b0, 1'b0, 16'd1001, 2'd2, 1'b0, "peak_trip");
        holdoff(16'd1001, 2'd2);
        // A surviving partial window would complete early, on the fifth sample.
        for (int i = 0; i < 7; i++) step(1'b1, 16'd500, 1'b0, 1'b1, 16'd1001, 2'd2, 1'b0, "discard_fill");
        step(1'b1, 16'd500, 1'b0, 1'b1, 16'd500, 2'd2, 1'b0, "discard_load");
        step(1'b0, 16'd0, 1'b0, 1'b1, 16'd500, 2'd2, 1'b0, "avg_low_notrip");
    endtask

    task automatic test_clear_coincide();
        step(1'b1, 16'd2500, 1'b1, 1'b0, 16'd500, 2'd1, 1'b0, "clr_trip");
        holdoff(16'd500, 2'd1);
    endtask

    task automatic test_lockout();
        step(1'b0, 16'd0, 1'b1, 1'b1, 16'd500, 2'd0, 1'b0, "clear_in_run");
        step(1'b1, 16'd2000, 1'b0, 1'b0, 16'd500, 2'd1, 1'b0, "lock_trip1");
        holdoff(16'd500, 2'd1);
        step(1'b1, 16'd2000, 1'b0, 1'b0, 16'd500, 2'd2, 1'b0, "lock_trip2");
        holdoff(16'd500, 2'd2);
        step(1'b1, 16'd4000, 1'b0, 1'b0, 16'd500, 2'd3, 1'b1, "lock_trip3");
        for (int i = 0; i < 150; i++) step(1'b1, 16'd3000, 1'b0, 1'b0, 16'd500, 2'd3, 1'b1, "lockout_hold");
        step(1'b0, 16'd0, 1'b1, 1'b1, 16'd500, 2'd0, 1'b0, "lockout_clear");
        step(1'b0, 16'd0, 1'b0, 1'b1, 16'd500, 2'd0, 1'b0, "after_clear");
    endtask

    task automatic test_reset_holdoff();
        for (int i = 0; i < 3; i++) step(1'b1, 16'd700, 1'b0, 1'b1, 16'd500, 2'd0, 1'b0, "rst_prefill");
        step(1'b1, 16'd2200, 1'b0, 1'b0, 16'd500, 2'd1, 1'b0, "rst_trip");
        for (int i = 0; i < 49; i++) step(1'b0, 16'd0, 1'b0, 1'b0, 16'd500, 2'd1, 1'b0, "rst_holdoff");
        drain();
        reset = 1'b0;
        #1;
        checks++; if (motor_enable !== 1'b1) begin failures++; $display("FAIL async_rst.motor_enable got=%0b exp=1", motor_enable); end
        checks++; if (motor_reset !== 1'b0) begin failures++; $display("FAIL async_rst.motor_reset got=%0b exp=0", motor_reset); end
        checks++; if (avg_value !== 16'd0) begin failures++; $display("FAIL async_rst.avg_value got=%0d exp=0", avg_value); end
        checks++; if (trip_count !== 2'd0) begin failures++; $display("FAIL async_rst.trip_count got=%0d exp=0", trip_count); end
        checks++; if (fault_latched !== 1'b0) begin failures++; $display("FAIL async_rst.fault_latched got=%0b exp=0", fault_latched); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 7; i++) step(1'b1, 16'd1200, 1'b0, 1'b1, 16'd0, 2'd0, 1'b0, "post_rst_fill");
        step(1'b1, 16'd1200, 1'b0, 1'b1, 16'd1200, 2'd0, 1'b0, "post_rst_load");
        step(1'b0, 16'd0, 1'b0, 1'b0, 16'd1200, 2'd1, 1'b0, "post_rst_trip");
        drain();
    endtask

    initial begin
        test_reset();
        test_avg_equal();
        test_avg_trip();
        test_peak_mid();
        test_clear_coincide();
        test_lockout();
        test_reset_holdoff();
        drain();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty got=%0d pending exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/overcurrent_guard.md
OVERCURRENT_GUARD -- requirements
Module: overcurrent_guard

Interface
REQ-001 SHALL have parameter AVG_THRESH, default 16'd1000, meaning trip level for the block average (current units).
REQ-002 SHALL have parameter PEAK_THRESH, default 16'd2000, meaning instantaneous trip level.
REQ-003 SHALL have parameter AVG_LOG2, default 3, meaning window length = 2^AVG_LOG2 samples (legal 1..6).
REQ-004 SHALL have parameter HOLDOFF_CYCLES, default 100_000_000, meaning clk cycles the motor is held off after a trip (>=2).
REQ-005 SHALL have parameter MAX_TRIPS, default 3, meaning the number of trips that forces lockout (1..3).
REQ-006 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port current_value  input  16  unsigned current sample from the sensing stage.
REQ-009 SHALL have port sample_valid  input  1  one-cycle strobe qualifying current_value.
REQ-010 SHALL have port clear  input  1  level; releases lockout and zeroes trip_count.
REQ-011 SHALL have port motor_enable  output  1  high = motor drive permitted.
REQ-012 SHALL have port motor_reset  output  1  high = force downstream motor controller into reset; always the inverse of motor_enable.
REQ-013 SHALL have port avg_value  output  16  last completed block average, for display.
REQ-014 SHALL have port trip_count  output  2  trips since last clear, saturating at MAX_TRIPS.
REQ-015 SHALL have port fault_latched  output  1  high only in LOCKOUT.

Function
REQ-016 SHALL implement the states RUN, HOLDOFF and LOCKOUT; motor_enable SHALL be 1 only in RUN.
REQ-017 In RUN, each clk edge with sample_valid=1 SHALL add current_value to a (16+AVG_LOG2)-bit accumulator and increment a sample counter; there SHALL be no overflow possible.
REQ-018 On the edge accepting sample 2^AVG_LOG2, avg_value SHALL load (accumulator+current_value)>>AVG_LOG2, and the accumulator and counter SHALL clear.
REQ-019 On the edge after avg_value updates, if avg_value > AVG_THRESH (strict), a trip SHALL occur; equality SHALL NOT trip.
REQ-020 On any RUN edge with sample_valid=1 and current_value >= PEAK_THRESH, a trip SHALL occur on that same edge.
REQ-021 On a trip, trip_count SHALL increment; if the new count equals MAX_TRIPS, the next state SHALL be LOCKOUT, otherwise HOLDOFF.
REQ-022 A peak and an average trip on the same edge SHALL count as one trip.
REQ-023 Entry to HOLDOFF or LOCKOUT SHALL clear the accumulator and sample counter; sample_valid SHALL be ignored outside RUN.
REQ-024 HOLDOFF SHALL last exactly HOLDOFF_CYCLES clk edges, counted from the entry edge, and then return to RUN with an empty window.
REQ-025 LOCKOUT SHALL be exited only by clear=1, which returns the block to RUN with trip_count=0 on the next edge.
REQ-026 clear=1 in RUN or HOLDOFF SHALL zero trip_count and SHALL NOT change state.
REQ-027 If clear and a trip coincide, the clear SHALL apply first, so that trip_count becomes 1 and the state becomes HOLDOFF (or LOCKOUT if MAX_TRIPS=1).
REQ-028 trip_count SHALL never exceed MAX_TRIPS; avg_value SHALL hold between windows and SHALL NOT be cleared by trips.
REQ-029 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-030 reset=0 SHALL asynchronously force: state RUN, motor_enable=1, motor_reset=0, avg_value=0, trip_count=0, fault_latched=0, accumulator, sample counter and holdoff counter all 0.
REQ-031 Reset asserted mid-window or mid-HOLDOFF SHALL discard partial sums and counts; operation SHALL resume from the REQ-030 values on the first edge after release.

Verification (defaults, HOLDOFF_CYCLES=100 for simulation)
REQ-032 Bench SHALL apply eight valid samples of 1000 -> avg_value=1000 one edge after the eighth sample; no trip (equality).
REQ-033 Bench SHALL apply eight valid samples of 1001 -> avg_value=1001; motor_enable=0 one edge later; trip_count=1; motor_enable=1 again after exactly 100 cycles.
REQ-034 Bench SHALL apply a single sample of 2000 in the middle of a window -> motor_enable=0 at that edge; the partial window SHALL be discarded; avg_value unchanged.
REQ-035 Bench SHALL produce three successive peak trips -> after the third trip, fault_latched=1, trip_count=3, motor held off beyond 100 cycles; after a clear pulse, RUN with trip_count=0.
REQ-036 Bench SHALL assert clear on the same edge as a peak trip while trip_count=2 -> trip_count=1, state HOLDOFF, fault_latched=0.
REQ-037 Bench SHALL assert reset=0 during HOLDOFF at cycle 50 -> motor_enable=1 and all outputs 0 immediately, without waiting for a clock edge.
